matmul_compute_ctrl: RTL and testbench

- Sequences the compute phase of the matrix-multiply accelerator: C[M][N] = A[M][K] * B[K][N].
- Waits for `input_mems` to raise `matrices_loaded`, then generates A/B read addresses in dot-product order.
- Emits operand-valid/first/last markers aligned to the 1-cycle memory read latency, for the downstream MAC.
- Pulses `compute_finished` so `input_mems` can accept the next matrices.

---
 rtl/matmul_compute_ctrl_if.sv | 41 ++++
 rtl/matmul_compute_ctrl.sv | 173 +++++++++++++++++
 tb/tb_matmul_compute_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_compute_ctrl_if.sv
// matmul_compute_ctrl_if
//   Bus between the compute-phase controller and its neighbours.
//   matrices_loaded, K      : input_mems -> controller (K stable while loaded)
//   compute_finished        : controller -> input_mems, one-cycle pulse
//   A_read_addr/B_read_addr : controller -> operand memories (1-cycle read latency)
//   stall                   : MAC -> controller, beat cannot be accepted
//   op_valid/op_first/op_last/c_addr : controller -> MAC, aligned with A_data/B_data
//   master = controller side, slave = environment side.
interface matmul_compute_ctrl_if #(
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8
);
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int C_ADDR_BITS = $clog2(M * N);

    logic                   matrices_loaded;
    logic [K_BITS-1:0]      K;
    logic                   compute_finished;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic                   stall;
    logic                   op_valid;
    logic                   op_first;
    logic                   op_last;
    logic [C_ADDR_BITS-1:0] c_addr;

    modport master (
        input  matrices_loaded, K, stall,
        output compute_finished, A_read_addr, B_read_addr,
               op_valid, op_first, op_last, c_addr
    );

    modport slave (
        output matrices_loaded, K, stall,
        input  compute_finished, A_read_addr, B_read_addr,
               op_valid, op_first, op_last, c_addr
    );
endinterface

// File: rtl/matmul_compute_ctrl.sv
// matmul_compute_ctrl
//   Sequences the compute phase of C[M][N] = A[M][K] * B[K][N]. After
//   matrices_loaded it walks (m, n, k) in dot-product order, drives A/B read
//   addresses and presents operand-valid/first/last markers one cycle later,
//   aligned with the 1-cycle memory read data. Pulses compute_finished when
//   the last beat has been consumed.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : matmul_compute_ctrl_if.master (load/finish handshake, operand
//           addresses, stall, beat markers and c_addr)
module matmul_compute_ctrl #(
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    matmul_compute_ctrl_if.master bus
);
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int C_ADDR_BITS = $clog2(M * N);
    localparam int M_BITS      = (M > 1) ? $clog2(M) : 1;
    localparam int N_BITS      = (N > 1) ? $clog2(N) : 1;

    localparam logic [K_BITS-1:0]      MAXK_V = K_BITS'(MAXK);
    localparam logic [M_BITS-1:0]      M_LAST = M_BITS'(M - 1);
    localparam logic [N_BITS-1:0]      N_LAST = N_BITS'(N - 1);
    localparam logic [B_ADDR_BITS-1:0] N_B    = B_ADDR_BITS'(N);
    localparam logic [C_ADDR_BITS-1:0] N_C    = C_ADDR_BITS'(N);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    // Next beat to issue and its running row bases.
    logic [K_BITS-1:0]      keff;
    logic [K_BITS-1:0]      k_last;
    logic [K_BITS-1:0]      k;
    logic [M_BITS-1:0]      m;
    logic [N_BITS-1:0]      n;
    logic [A_ADDR_BITS-1:0] m_base;   // m * keff
    logic [B_ADDR_BITS-1:0] k_base;   // k * N
    logic [C_ADDR_BITS-1:0] c_base;   // m * N

    // Addresses of the beat currently presented downstream.
    logic [A_ADDR_BITS-1:0] a_held;
    logic [B_ADDR_BITS-1:0] b_held;

    logic                   finished_r;
    logic                   valid_r;
    logic                   first_r;
    logic                   last_r;
    logic [C_ADDR_BITS-1:0] c_addr_r;

    logic [K_BITS-1:0]      k_sat;
    logic [A_ADDR_BITS-1:0] a_next;
    logic [B_ADDR_BITS-1:0] b_next;
    logic [C_ADDR_BITS-1:0] c_next;
    logic                   issue;
    logic                   k_wrap;
    logic                   n_wrap;
    logic                   last_beat;

    assign k_sat     = (bus.K > MAXK_V) ? MAXK_V : bus.K;
    assign a_next    = m_base + A_ADDR_BITS'(k);
    assign b_next    = k_base + B_ADDR_BITS'(n);
    assign c_next    = c_base + C_ADDR_BITS'(n);
    assign issue     = (state == RUN) && !bus.stall;
    assign k_wrap    = (k == k_last);
    assign n_wrap    = (n == N_LAST);
    assign last_beat = k_wrap && n_wrap && (m == M_LAST);

    // When a beat issues, the memory must see the new beat's address this
    // cycle; in every other cycle it re-reads the presented beat so that
    // A_data/B_data stay valid across a stall (and hold after the run).
    assign bus.A_read_addr = issue ? a_next : a_held;
    assign bus.B_read_addr = issue ? b_next : b_held;

    assign bus.compute_finished = finished_r;
    assign bus.op_valid         = valid_r;
    assign bus.op_first         = first_r;
    assign bus.op_last          = last_r;
    assign bus.c_addr           = c_addr_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            keff       <= '0;
            k_last     <= '0;
            k          <= '0;
            m          <= '0;
            n          <= '0;
            m_base     <= '0;
            k_base     <= '0;
            c_base     <= '0;
            a_held     <= '0;
            b_held     <= '0;
            finished_r <= 1'b0;
            valid_r    <= 1'b0;
            first_r    <= 1'b0;
            last_r     <= 1'b0;
            c_addr_r   <= '0;
        end else begin
            finished_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.matrices_loaded) begin
                        keff   <= k_sat;
                        k_last <= k_sat - 1'b1;
                        k      <= '0;
                        m      <= '0;
                        n      <= '0;
                        m_base <= '0;
                        k_base <= '0;
                        c_base <= '0;
                        if (k_sat == '0) begin
                            finished_r <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        valid_r  <= 1'b1;
                        first_r  <= (k == '0);
                        last_r   <= k_wrap;
                        c_addr_r <= c_next;
                        a_held   <= a_next;
                        b_held   <= b_next;
                        if (k_wrap) begin
                            k      <= '0;
                            k_base <= '0;
                            if (n_wrap) begin
                                n      <= '0;
                                m      <= m + 1'b1;
                                m_base <= m_base + A_ADDR_BITS'(keff);
                                c_base <= c_base + N_C;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            k      <= k + 1'b1;
                            k_base <= k_base + N_B;
                        end
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final beat is ever presented here.
                    if (!bus.stall) begin
                        valid_r    <= 1'b0;
                        first_r    <= 1'b0;
                        last_r     <= 1'b0;
                        finished_r <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_compute_ctrl.sv
// tb_matmul_compute_ctrl
//   Directed bench for matmul_compute_ctrl with a 1-cycle operand memory
//   model, an expected-beat queue built from the matrix loops, a bench-side
//   MAC and a reference matrix product.
module tb_matmul_compute_ctrl;
    localparam int M      = 7;
    localparam int N      = 9;
    localparam int MAXK   = 8;
    localparam int K_BITS = $clog2(MAXK + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matmul_compute_ctrl_if #(.M(M), .N(N), .MAXK(MAXK)) bus ();

    matmul_compute_ctrl #(.M(M), .N(N), .MAXK(MAXK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int aa;
        int ba;
        int ca;
        int first;
        int last;
        int av;
        int bv;
    } beat_t;

    int tests = 0;
    int fails = 0;

    // Operand memories, 1-cycle read latency.
    logic [7:0] amem [M*MAXK];
    logic [7:0] bmem [MAXK*N];
    logic [7:0] A_data;
    logic [7:0] B_data;
    int         a_rd;
    int         b_rd;

    always @(posedge clk) begin
        A_data <= amem[bus.A_read_addr];
        B_data <= bmem[bus.B_read_addr];
        a_rd   <= int'(bus.A_read_addr);
        b_rd   <= int'(bus.B_read_addr);
    end

    int    ag [M][MAXK];
    int    bg [MAXK][N];
    int    c_ref [M*N];
    int    c_got [M*N];
    beat_t exp_q [$];
    beat_t hb;
    int    got_a [$];
    int    got_b [$];
    int    got_c [$];
    int    got_f [$];
    int    got_l [$];

    bit chk_en = 1'b0;
    bit cf_exp = 1'b0;
    bit cf_nxt;
    bit k0_arm = 1'b0;
    int consumed, valid_cyc, first_valid, cf_cnt, cyc, acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, expv);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " op_valid"},         32'(bus.op_valid), 0);
        chk({tag, " op_first"},         32'(bus.op_first), 0);
        chk({tag, " op_last"},          32'(bus.op_last), 0);
        chk({tag, " c_addr"},           32'(bus.c_addr), 0);
        chk({tag, " compute_finished"}, 32'(bus.compute_finished), 0);
        chk({tag, " A_read_addr"},      32'(bus.A_read_addr), 0);
        chk({tag, " B_read_addr"},      32'(bus.B_read_addr), 0);
    endtask

    // Compare process: every cycle checks compute_finished, and every
    // presented beat against the head of the expected-beat queue.
    always @(negedge clk) begin
        if (chk_en) begin
            cf_nxt = 1'b0;
            chk("compute_finished", 32'(bus.compute_finished), 32'(cf_exp));
            if (bus.compute_finished === 1'b1) cf_cnt++;
            if (k0_arm && bus.matrices_loaded === 1'b1) begin
                cf_nxt = 1'b1;
                k0_arm = 1'b0;
            end
            if (bus.op_valid !== 1'b0) begin
                valid_cyc++;
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected op_valid", 32'(bus.op_valid), 0);
                end else begin
                    hb = exp_q[0];
                    chk("c_addr",   32'(bus.c_addr), hb.ca);
                    chk("op_first", 32'(bus.op_first), hb.first);
                    chk("op_last",  32'(bus.op_last), hb.last);
                    chk("A_data",   32'(A_data), hb.av);
                    chk("B_data",   32'(B_data), hb.bv);
                    chk("A addr read", a_rd, hb.aa);
                    chk("B addr read", b_rd, hb.ba);
                    if (bus.stall) begin
                        chk("stalled A_read_addr", 32'(bus.A_read_addr), hb.aa);
                        chk("stalled B_read_addr", 32'(bus.B_read_addr), hb.ba);
                    end else begin
                        void'(exp_q.pop_front());
                        consumed++;
                        got_a.push_back(a_rd);
                        got_b.push_back(b_rd);
                        got_c.push_back(int'(bus.c_addr));
                        got_f.push_back(int'(bus.op_first));
                        got_l.push_back(int'(bus.op_last));
                        acc = (bus.op_first ? 0 : acc) + int'(A_data) * int'(B_data);
                        if (bus.op_last) c_got[bus.c_addr] = acc;
                        if (exp_q.size() == 0) cf_nxt = 1'b1;
                    end
                end
            end
            cf_exp = cf_nxt;
        end
    end

    // mode 0: no stall, 1: 30% random stall, 2: 5-cycle stall on last beat of c_addr 10.
    // abort_at >= 0 pulls reset low once that many beats have been consumed.
    task automatic run(input int kin, input int mode, input int abort_at);
        int keff, hold_n, hold_seen;
        bit done;
        keff = (kin > MAXK) ? MAXK : kin;
        for (int mi = 0; mi < M; mi++)
            for (int ki = 0; ki < MAXK; ki++) begin
                ag[mi][ki] = (mi * 7 + ki * 3 + kin) % 16 + 1;
                if (ki < keff) amem[mi*keff+ki] = 8'(ag[mi][ki]);
            end
        for (int ki = 0; ki < MAXK; ki++)
            for (int ni = 0; ni < N; ni++) begin
                bg[ki][ni] = (ki * 5 + ni * 11 + 2) % 13 + 1;
                bmem[ki*N+ni] = 8'(bg[ki][ni]);
            end
        exp_q.delete();
        got_a.delete(); got_b.delete(); got_c.delete(); got_f.delete(); got_l.delete();
        for (int mi = 0; mi < M; mi++)
            for (int ni = 0; ni < N; ni++) begin
                c_ref[mi*N+ni] = 0;
                c_got[mi*N+ni] = -1;
                for (int ki = 0; ki < keff; ki++) begin
                    exp_q.push_back('{mi*keff+ki, ki*N+ni, mi*N+ni, int'(ki == 0),
                                      int'(ki == keff-1), ag[mi][ki], bg[ki][ni]});
                    c_ref[mi*N+ni] += ag[mi][ki] * bg[ki][ni];
                end
            end
        consumed = 0; valid_cyc = 0; first_valid = -1; cf_cnt = 0; cyc = 0;
        k0_arm = (keff == 0);
        hold_n = 0; hold_seen = 0; done = 1'b0;
        bus.stall = 1'b0;
        bus.K = K_BITS'(kin);
        bus.matrices_loaded = 1'b1;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.compute_finished === 1'b1) begin
                done = 1'b1;
                bus.matrices_loaded = 1'b0;
                bus.stall = 1'b0;
            end else if (abort_at >= 0 && consumed >= abort_at) begin
                chk_en = 1'b0;
                reset = 1'b0;
                #1;
                check_zero_outputs("async reset");
                bus.matrices_loaded = 1'b0;
                bus.stall = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("cf in reset", 32'(bus.compute_finished), 0);
                    chk("op_valid in reset", 32'(bus.op_valid), 0);
                end
                @(posedge clk); #1;
                reset = 1'b1;
                exp_q.delete();
                cf_exp = 1'b0;
                k0_arm = 1'b0;
                @(posedge clk); #1;
                chk("cf after reset", 32'(bus.compute_finished), 0);
                chk_en = 1'b1;
                return;
            end else if (mode == 1) begin
                bus.stall = ($urandom_range(0, 99) < 30);
            end else if (mode == 2 && bus.op_valid === 1'b1 && bus.c_addr == 10 && bus.op_last === 1'b1) begin
                hold_seen++;
                if (hold_n < 5) begin
                    hold_n++;
                    bus.stall = 1'b1;
                    #1;
                    chk("hold A_read_addr", 32'(bus.A_read_addr), 15);
                    chk("hold B_read_addr", 32'(bus.B_read_addr), 64);
                end else begin
                    bus.stall = 1'b0;
                end
            end else begin
                bus.stall = 1'b0;
            end
        end
        chk("compute_finished seen within budget", 32'(done), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("compute_finished pulses", cf_cnt, 1);
        chk("beats consumed", consumed, M * N * keff);
        if (keff > 0)
            for (int i = 0; i < M * N; i++)
                chk($sformatf("C[%0d]", i), c_got[i], c_ref[i]);
        if (mode == 0) begin
            chk("cycles to compute_finished", cyc, (keff == 0) ? 1 : M * N * keff + 2);
            chk("op_valid cycles", valid_cyc, M * N * keff);
            if (keff > 0) chk("first op_valid latency", first_valid, 2);
        end
        if (mode == 2) chk("cycles c_addr 10 last presented", hold_seen, 6);
    endtask

    initial begin
        reset = 1'b1;
        bus.matrices_loaded = 1'b0;
        bus.K = '0;
        bus.stall = 1'b0;
        #2 reset = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run(8, 0, -1);
        chk("beat count K=8", got_c.size(), 504);
        if (got_c.size() == 504) begin
            chk("beat0 A addr", got_a[0], 0);
            chk("beat0 B addr", got_b[0], 0);
            chk("beat0 op_first", got_f[0], 1);
            chk("beat8 A addr", got_a[8], 0);
            chk("beat8 B addr", got_b[8], 1);
            chk("final c_addr", got_c[503], 62);
            chk("final op_last", got_l[503], 1);
        end

        run(1, 0, -1);
        chk("beat count K=1", got_c.size(), 63);
        if (got_c.size() == 63) begin
            chk("K=1 beat10 c_addr", got_c[10], 10);
            chk("K=1 beat10 A addr", got_a[10], 1);
            chk("K=1 beat10 B addr", got_b[10], 1);
            chk("K=1 beat62 c_addr", got_c[62], 62);
            chk("K=1 beat62 first", got_f[62], 1);
            chk("K=1 beat62 last", got_l[62], 1);
        end

        run(0, 0, -1);
        run(15, 0, -1);
        run(8, 1, -1);
        run(8, 2, -1);
        run(8, 0, 100);
        run(8, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
